neuron_mac: RTL and testbench

//  Fixed-point multiply-accumulate for one neuron: streams NUM_INPUTS activations, fetches matching

---
 rtl/nn_pkg.sv | 38 +++
 rtl/fxp_mul.sv | 27 ++
 rtl/neuron_mac.sv | 112 +++++++++++
 tb/tb_neuron_mac.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared fixed-point constants, FSM state type and the 32-bit saturation helper
// for the neuron datapath.
package nn_pkg;

    localparam int DATA_W    = 32;
    localparam int FRAC_BITS = 16;
    localparam int ACC_W     = 48;

    // Q15.16 constants
    localparam logic [DATA_W-1:0] ONE     = 32'h0001_0000;
    localparam logic [DATA_W-1:0] Q_MAX   = 32'h7FFF_FFFF;
    localparam logic [DATA_W-1:0] Q_MIN   = 32'h8000_0000;

    // Saturation bounds expressed at accumulator width
    localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-31){1'b0}}, {31{1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-31){1'b1}}, {31{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FINAL = 2'd3
    } state_t;

    // Clamp an accumulator-width signed value into the signed 32-bit range
    function automatic logic [DATA_W-1:0] sat32(input logic signed [ACC_W-1:0] v);
        logic [DATA_W-1:0] r;
        if (v > SAT_HI) begin
            r = Q_MAX;
        end else if (v < SAT_LO) begin
            r = Q_MIN;
        end else begin
            r = v[DATA_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/fxp_mul.sv
// Combinational signed Q15.16 multiply: full 64-bit product, arithmetic shift
// right by the fractional width (rounds toward -inf), resized to the
// accumulator width.
module fxp_mul
    import nn_pkg::*;
#(
    parameter int FRAC = FRAC_BITS,
    parameter int OUT_W = ACC_W
) (
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [OUT_W-1:0]  p
);

    logic signed [2*DATA_W-1:0] a_ext;
    logic signed [2*DATA_W-1:0] b_ext;
    logic signed [2*DATA_W-1:0] full;

    // Sign-extend both operands so the product is a true signed 64-bit value
    always_comb begin
        a_ext = (2*DATA_W)'(a);
        b_ext = (2*DATA_W)'(b);
        full  = a_ext * b_ext;
        p     = OUT_W'(full >>> FRAC);
    end

endmodule

// File: rtl/neuron_mac.sv
// One-neuron multiply-accumulate: accepts NUM_INPUTS activations, pairs each
// with the weight read from a 1-cycle-latency ROM at the same index, adds the
// bias and emits a saturated 32-bit pre-activation with a one-cycle pulse.
module neuron_mac
    import nn_pkg::*;
#(
    parameter int NUM_INPUTS = 784,
    parameter int ADDR_W     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [31:0]       bias,
    input  logic [31:0]       data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic [ADDR_W-1:0] weight_addr,
    input  logic [31:0]       weight_data,
    output logic [31:0]       sum_out,
    output logic              sum_valid,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_INPUTS - 1);

    state_t                    state;
    logic [ADDR_W-1:0]         count;
    logic signed [DATA_W-1:0]  d_reg;
    logic                      p_valid;
    logic signed [ACC_W-1:0]   acc;
    logic signed [DATA_W-1:0]  bias_reg;
    logic signed [ACC_W-1:0]   prod;
    logic signed [ACC_W-1:0]   final_sum;
    logic                      accept;

    // The ROM is addressed straight from the counter so the weight for the
    // accepted activation arrives exactly when d_reg holds it.
    assign weight_addr = count;
    assign accept      = data_valid & data_ready;
    assign final_sum   = acc + ACC_W'(bias_reg);

    fxp_mul #(
        .FRAC  (FRAC_BITS),
        .OUT_W (ACC_W)
    ) u_mul (
        .a (d_reg),
        .b (weight_data),
        .p (prod)
    );

    // Control FSM, input capture, accumulation and result register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            count      <= '0;
            d_reg      <= '0;
            p_valid    <= 1'b0;
            acc        <= '0;
            bias_reg   <= '0;
            sum_out    <= '0;
            sum_valid  <= 1'b0;
            data_ready <= 1'b0;
            busy       <= 1'b0;
        end else begin
            sum_valid <= 1'b0;
            p_valid   <= 1'b0;

            // Second pipeline stage runs whenever a product is pending,
            // independent of the state, so the last one lands during DRAIN.
            if (p_valid) begin
                acc <= acc + prod;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        acc        <= '0;
                        count      <= '0;
                        bias_reg   <= bias;
                        data_ready <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (accept) begin
                        d_reg   <= data_in;
                        p_valid <= 1'b1;
                        count   <= count + 1'b1;
                        if (count == LAST_IDX) begin
                            data_ready <= 1'b0;
                            state      <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    state <= ST_FINAL;
                end
                ST_FINAL: begin
                    sum_out   <= sat32(final_sum);
                    sum_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac with NUM_INPUTS=4 and a behavioural 1-cycle
// weight ROM. Expected sums are pushed to a queue when a neuron is started and
// popped by the monitor on sum_valid.
module tb_neuron_mac;

    localparam int N = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] bias = '0;
    logic [31:0] data_in = '0;
    logic        data_valid = 1'b0;
    logic        data_ready;
    logic [1:0]  weight_addr;
    logic [31:0] weight_data = '0;
    logic [31:0] sum_out;
    logic        sum_valid;
    logic        busy;

    logic [31:0] xv [N];
    logic [31:0] wv [N];

    logic [31:0] exp_q [$];
    logic [31:0] last_exp = '0;
    int n_checks = 0;
    int n_pass = 0;
    int n_results = 0;
    int cycle = 0;
    int idx = 0;
    int last_acc = 0;
    logic sv_prev = 1'b0;

    neuron_mac #(.NUM_INPUTS(N)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .bias        (bias),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .weight_addr (weight_addr),
        .weight_data (weight_data),
        .sum_out     (sum_out),
        .sum_valid   (sum_valid),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    // Weight ROM, one cycle read latency
    always @(posedge clock) weight_data <= wv[weight_addr];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // Reference sum: 48-bit wrapping accumulation of (x*w)>>>16, plus bias, clamped
    function automatic logic [31:0] model(input logic [31:0] b);
        logic signed [47:0] a;
        logic signed [47:0] s;
        logic signed [63:0] p;
        a = '0;
        for (int i = 0; i < N; i++) begin
            p = longint'($signed(xv[i])) * longint'($signed(wv[i]));
            a = a + 48'(p >>> 16);
        end
        s = a + 48'($signed(b));
        if (s > 48'sh0000_7FFF_FFFF) return 32'h7FFF_FFFF;
        if (s < -48'sh0000_8000_0000) return 32'h8000_0000;
        return s[31:0];
    endfunction

    // Monitor: weight address on every accept, result/latency/pulse on sum_valid
    always @(negedge clock) begin
        if (reset_n) begin
            if (data_valid && data_ready) begin
                chk("weight_addr", 64'(weight_addr), 64'(idx));
                idx = idx + 1;
                if (idx == N) last_acc = cycle;
            end
            if (sum_valid) begin
                chk("sum_valid_expected", 64'(exp_q.size() != 0), 64'd1);
                chk("sum_valid_pulse", 64'(sv_prev), 64'd0);
                chk("latency", 64'(cycle), 64'(last_acc + 3));
                if (exp_q.size() != 0) begin
                    last_exp = exp_q.pop_front();
                    chk("sum_out", 64'(sum_out), 64'(last_exp));
                end
                n_results++;
            end
            sv_prev = sum_valid;
        end else begin
            sv_prev = 1'b0;
        end
    end

    // One neuron: pattern bit (step % plen) drives data_valid; start is also
    // pulsed at step 'glitch'; abort_after >= 0 pulls reset after that many accepts
    task automatic run(input logic [31:0] b, input int pat, input int plen,
                       input int glitch, input int abort_after);
        int sent;
        int step;
        int r0;
        logic [31:0] e;
        e = model(b);
        idx = 0;
        r0 = n_results;
        if (abort_after < 0) exp_q.push_back(e);
        @(posedge clock); #1;
        start = 1'b1;
        bias = b;
        @(posedge clock); #1;
        start = 1'b0;
        chk("busy_accum", 64'(busy), 64'd1);
        chk("ready_accum", 64'(data_ready), 64'd1);
        sent = 0;
        step = 0;
        while (sent < N && step < 200) begin
            data_valid = pat[step % plen];
            data_in = xv[sent];
            start = (step == glitch);
            @(negedge clock);
            if (data_valid && data_ready) sent++;
            @(posedge clock); #1;
            step++;
            if (abort_after >= 0 && sent == abort_after) break;
        end
        data_valid = 1'b0;
        start = 1'b0;
        if (abort_after >= 0) begin
            reset_n = 1'b0;
            #1;
            chk("rst_data_ready", 64'(data_ready), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_sum_valid", 64'(sum_valid), 64'd0);
            chk("rst_sum_out", 64'(sum_out), 64'd0);
            chk("rst_weight_addr", 64'(weight_addr), 64'd0);
            repeat (3) @(posedge clock);
            #1;
            reset_n = 1'b1;
            repeat (8) @(posedge clock);
            #1;
            chk("abort_no_result", 64'(n_results), 64'(r0));
        end else begin
            for (int t = 0; t < 12 && n_results == r0; t++) begin
                @(posedge clock); #1;
            end
            chk("result_timeout", 64'(n_results), 64'(r0 + 1));
            repeat (3) @(posedge clock);
            #1;
            chk("sum_out_hold", 64'(sum_out), 64'(e));
            chk("busy_idle", 64'(busy), 64'd0);
        end
    endtask

    task automatic set_vec(input logic [31:0] x0, x1, x2, x3, w0, w1, w2, w3);
        xv[0] = x0; xv[1] = x1; xv[2] = x2; xv[3] = x3;
        wv[0] = w0; wv[1] = w1; wv[2] = w2; wv[3] = w3;
    endtask

    initial begin
        set_vec(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clock);
        #1;
        chk("reset_sum_out", 64'(sum_out), 64'd0);
        chk("reset_sum_valid", 64'(sum_valid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_ready", 64'(data_ready), 64'd0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Basic sum: x = 1..4, w = 0.5, bias = -1.0 -> 4.0
        set_vec(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000,
                32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'h0000_8000);
        run(32'hFFFF_0000, 1, 1, -1, -1);

        // Negative result: w = -1.0, bias = 0 -> -10.0
        set_vec(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000,
                32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000);
        run(32'h0000_0000, 1, 1, -1, -1);

        // Positive clamp; two full-scale terms keep the 48-bit accumulator in range
        set_vec(32'h7FFF_0000, 32'h7FFF_0000, 32'h0, 32'h0,
                32'h7FFF_0000, 32'h7FFF_0000, 32'h0, 32'h0);
        run(32'h0000_0000, 1, 1, -1, -1);

        // Negative clamp
        set_vec(32'h7FFF_0000, 32'h7FFF_0000, 32'h0, 32'h0,
                32'h8001_0000, 32'h8001_0000, 32'h0, 32'h0);
        run(32'h0000_0000, 1, 1, -1, -1);

        // Backpressure: data_valid 1,0,0,1,0,1,1 on the basic-sum vectors
        set_vec(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000,
                32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'h0000_8000);
        run(32'hFFFF_0000, 7'b1101001, 7, -1, -1);

        // start pulsed mid-stream must be ignored
        run(32'hFFFF_0000, 1, 1, 1, -1);

        // data_valid high while idle: never accepted
        data_valid = 1'b1;
        data_in = 32'h0100_0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("idle_ready", 64'(data_ready), 64'd0);
            @(posedge clock); #1;
        end
        data_valid = 1'b0;
        run(32'hFFFF_0000, 1, 1, -1, -1);

        // Reset after two accepts, then a clean restart
        run(32'hFFFF_0000, 1, 1, -1, 2);
        run(32'hFFFF_0000, 1, 1, -1, -1);

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
